instr_mem_arbiter: RTL and testbench

//  Shares one single-port instruction SRAM (12-bit word address, 32-bit data) between NumReq

---
 rtl/instr_mem_arb_pkg.sv | 28 ++
 rtl/rr_arbiter.sv | 49 ++++
 rtl/instr_mem_arbiter.sv | 107 ++++++++++
 tb/tb_instr_mem_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : instr_mem_arb_pkg
//  Brief   : Shared types and constants for the instruction-SRAM arbiter.
//  Revision: 1.0 - initial release
// ============================================================================
package instr_mem_arb_pkg;

    localparam int NumReqMax   = 4;
    localparam int c_ID_W      = $clog2(NumReqMax);
    localparam int c_SRAM_AW   = 12;
    localparam int c_SRAM_DW   = 32;

    typedef struct packed {
        logic              vld;
        logic [c_ID_W-1:0] id;
    } arb_tag_t;

    // Request bundle at the default SRAM geometry.
    typedef struct packed {
        logic                 we;
        logic [c_SRAM_AW-1:0] addr;
        logic [c_SRAM_DW-1:0] wdata;
        logic [c_SRAM_DW-1:0] wmask;
    } sram_req_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : rr_arbiter
//  Brief   : Combinational round-robin picker; owns the priority pointer.
//  Revision: 1.0 - initial release
// ============================================================================
module rr_arbiter
    import instr_mem_arb_pkg::*;
#(
    parameter int N = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      i_req,
    input  logic              i_advance,
    output logic [N-1:0]      o_gnt,
    output logic [c_ID_W-1:0] o_idx
);

    logic [c_ID_W-1:0] r_ptr;
    logic [c_ID_W-1:0] w_ptr_nxt;
    logic              w_found;

    // Scan upward from the pointer, wrapping modulo N; first requester wins.
    always_comb begin
        o_gnt   = '0;
        o_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!w_found && ((i_req & (N'(1) << ((int'(r_ptr) + k) % N))) != '0)) begin
                w_found = 1'b1;
                o_idx   = c_ID_W'((int'(r_ptr) + k) % N);
                o_gnt   = N'(1) << ((int'(r_ptr) + k) % N);
            end
        end
    end

    assign w_ptr_nxt = c_ID_W'((int'(o_idx) + 1) % N);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= w_ptr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: rtl/instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : instr_mem_arbiter
//  Brief   : Round-robin sharing of one single-port instruction SRAM between
//            NumReq ports, with read responses routed back by a tag pipeline.
//  Revision: 1.0 - initial release
// ============================================================================
module instr_mem_arbiter
    import instr_mem_arb_pkg::*;
#(
    parameter int NumReq     = 2,
    parameter int Aw         = 12,
    parameter int Dw         = 32,
    parameter int MemLatency = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [NumReq-1:0]    req_i,
    input  logic [NumReq-1:0]    we_i,
    input  logic [NumReq*Aw-1:0] addr_i,
    input  logic [NumReq*Dw-1:0] wdata_i,
    input  logic [NumReq*Dw-1:0] wmask_i,
    output logic [NumReq-1:0]    gnt_o,
    output logic [NumReq-1:0]    rvalid_o,
    output logic [Dw-1:0]        rdata_o,
    output logic                 mem_req_o,
    output logic                 mem_we_o,
    output logic [Aw-1:0]        mem_addr_o,
    output logic [Dw-1:0]        mem_wdata_o,
    output logic [Dw-1:0]        mem_wmask_o,
    input  logic                 mem_gnt_i,
    input  logic [Dw-1:0]        mem_rdata_i,
    input  logic                 mem_rvalid_i,
    output logic                 err_o
);

    logic [NumReq-1:0] w_sel;
    logic [c_ID_W-1:0] w_idx;
    logic              w_any;
    logic              w_accept;
    arb_tag_t          r_tag [MemLatency];
    arb_tag_t          w_tail;
    logic              r_err;

    assign w_any    = |req_i;
    assign w_accept = w_any & mem_gnt_i;

    rr_arbiter #(
        .N (NumReq)
    ) u_rr_arbiter (
        .clk       (clock),
        .rst       (reset),
        .i_req     (req_i),
        .i_advance (w_accept),
        .o_gnt     (w_sel),
        .o_idx     (w_idx)
    );

    always_comb begin
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wmask_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (w_sel[i]) begin
                mem_we_o    = we_i[i];
                mem_addr_o  = addr_i[i*Aw +: Aw];
                mem_wdata_o = wdata_i[i*Dw +: Dw];
                mem_wmask_o = wmask_i[i*Dw +: Dw];
            end
        end
    end

    assign mem_req_o = w_any;
    assign gnt_o     = w_sel & {NumReq{w_accept}};

    // Stage 0 is written at acceptance; the tail lines up with mem_rvalid_i.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int s = 0; s < MemLatency; s++) begin
                r_tag[s] <= '0;
            end
            r_err <= 1'b0;
        end else begin
            r_tag[0].vld <= w_accept & ~mem_we_o;
            r_tag[0].id  <= w_idx;
            for (int s = 1; s < MemLatency; s++) begin
                r_tag[s] <= r_tag[s-1];
            end
            r_err <= r_err | (mem_rvalid_i ^ w_tail.vld);
        end
    end

    assign w_tail = r_tag[MemLatency-1];

    always_comb begin
        rvalid_o = '0;
        for (int i = 0; i < NumReq; i++) begin
            rvalid_o[i] = mem_rvalid_i & w_tail.vld & (w_tail.id == c_ID_W'(i));
        end
    end

    assign rdata_o = mem_rdata_i;
    assign err_o   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module  : tb_instr_mem_arbiter
//  Brief   : Two arbiter instances (read latency 1 and 3) on shared requests,
//            compared against a queue-based behavioural model.
//  Revision: 1.0 - initial release
// ============================================================================
module tb_instr_mem_arbiter;

    localparam int N  = 2;
    localparam int AW = 12;
    localparam int DW = 32;

    typedef struct {
        int cyc;
        int id;
    } iss_t;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    we  = '0;
    logic [N*AW-1:0] addr  = '0;
    logic [N*DW-1:0] wdata = '0;
    logic [N*DW-1:0] wmask = '0;
    logic            mgnt  = 1'b1;
    logic            mrv [2];
    logic [DW-1:0]   mrd [2];

    logic [N-1:0]    gnt [2];
    logic [N-1:0]    rv  [2];
    logic [DW-1:0]   rd  [2];
    logic            mreq [2];
    logic            mwe  [2];
    logic [AW-1:0]   maddr [2];
    logic [DW-1:0]   mwd [2];
    logic [DW-1:0]   mwm [2];
    logic            err [2];

    always #5 clk = ~clk;

    for (genvar gd = 0; gd < 2; gd++) begin : g_dut
        instr_mem_arbiter #(
            .NumReq     (N),
            .Aw         (AW),
            .Dw         (DW),
            .MemLatency ((gd == 0) ? 1 : 3)
        ) u_dut (
            .clock        (clk),
            .reset        (rst),
            .req_i        (req),
            .we_i         (we),
            .addr_i       (addr),
            .wdata_i      (wdata),
            .wmask_i      (wmask),
            .gnt_o        (gnt[gd]),
            .rvalid_o     (rv[gd]),
            .rdata_o      (rd[gd]),
            .mem_req_o    (mreq[gd]),
            .mem_we_o     (mwe[gd]),
            .mem_addr_o   (maddr[gd]),
            .mem_wdata_o  (mwd[gd]),
            .mem_wmask_o  (mwm[gd]),
            .mem_gnt_i    (mgnt),
            .mem_rdata_i  (mrd[gd]),
            .mem_rvalid_i (mrv[gd]),
            .err_o        (err[gd])
        );
    end

    int            n_cmp = 0;
    int            n_err = 0;
    int            ptr   = 0;
    int            cyc   = 0;
    logic [DW-1:0] mem [4096];
    iss_t          iq0 [$];
    iss_t          iq1 [$];
    logic          sp_v [2][4];
    logic [DW-1:0] sp_d [2][4];
    logic          em [2];
    logic [N-1:0]  obs_gnt;
    logic [N-1:0]  obs_rv [2];
    logic [DW-1:0] obs_rd [2];
    logic          obs_err [2];
    logic          last_acc = 1'b0;
    int            last_w   = -1;

    function automatic int lat(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    task automatic chk_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: check outputs at negedge against the model, then advance.
    task automatic cycle();
        int            w;
        int            due_id;
        logic          acc;
        logic          is_rd;
        logic [DW-1:0] rdv;
        logic [AW-1:0] wa;
        logic [DW-1:0] wm;
        @(negedge clk);
        w = -1;
        for (int k = 0; k < N; k++) begin
            if (w < 0 && req[(ptr + k) % N]) w = (ptr + k) % N;
        end
        acc     = (w >= 0) && mgnt;
        is_rd   = acc && !we[w];
        rdv     = '0;
        obs_gnt = gnt[0];
        for (int d = 0; d < 2; d++) begin
            obs_rv[d]  = rv[d];
            obs_rd[d]  = rd[d];
            obs_err[d] = err[d];
            if (!rst) begin
                chk_value("gnt", 64'(gnt[d]), acc ? (64'(1) << w) : 64'(0));
                chk_value("mem_req", 64'(mreq[d]), 64'(w >= 0));
                chk_value("mem_we", 64'(mwe[d]), (w >= 0) ? 64'(we[w]) : 64'(0));
                chk_value("mem_addr", 64'(maddr[d]), (w >= 0) ? 64'(addr[w*AW +: AW]) : 64'(0));
                chk_value("mem_wdata", 64'(mwd[d]), (w >= 0) ? 64'(wdata[w*DW +: DW]) : 64'(0));
                chk_value("mem_wmask", 64'(mwm[d]), (w >= 0) ? 64'(wmask[w*DW +: DW]) : 64'(0));
                due_id = -1;
                if (d == 0 && iq0.size() > 0 && iq0[0].cyc == cyc - lat(0)) begin
                    due_id = iq0[0].id;
                    void'(iq0.pop_front());
                end
                if (d == 1 && iq1.size() > 0 && iq1[0].cyc == cyc - lat(1)) begin
                    due_id = iq1[0].id;
                    void'(iq1.pop_front());
                end
                chk_value("rvalid", 64'(rv[d]), (mrv[d] && due_id >= 0) ? (64'(1) << due_id) : 64'(0));
                chk_value("rdata", 64'(rd[d]), 64'(mrd[d]));
                chk_value("err", 64'(err[d]), 64'(em[d]));
                if (mrv[d] != (due_id >= 0)) em[d] = 1'b1;
            end
        end
        if (acc) begin
            wa = addr[w*AW +: AW];
            if (we[w]) begin
                wm      = wmask[w*DW +: DW];
                mem[wa] = (mem[wa] & ~wm) | (wdata[w*DW +: DW] & wm);
            end else begin
                rdv = mem[wa];
                iq0.push_back(iss_t'{cyc: cyc, id: w});
                iq1.push_back(iss_t'{cyc: cyc, id: w});
            end
            ptr = (w + 1) % N;
        end
        last_acc = acc;
        last_w   = w;
        @(posedge clk);
        #1;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            for (int s = 3; s > 0; s--) begin
                sp_v[d][s] = sp_v[d][s-1];
                sp_d[d][s] = sp_d[d][s-1];
            end
            sp_v[d][0] = is_rd;
            sp_d[d][0] = rdv;
            mrv[d] = sp_v[d][lat(d)-1];
            mrd[d] = mrv[d] ? sp_d[d][lat(d)-1] : DW'($urandom);
        end
        if (rst) begin
            ptr = 0;
            iq0.delete();
            iq1.delete();
            em[0] = 1'b0;
            em[1] = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0;
        we  = '0;
        cycle();
        rst = 1'b0;
    endtask

    // Ports waiting for a grant keep their request stable.
    task automatic rand_inputs();
        for (int p = 0; p < N; p++) begin
            if (!(req[p] && !(last_acc && last_w == p))) begin
                req[p]             = ($urandom % 3) != 0;
                we[p]              = ($urandom % 3) == 0;
                addr[p*AW +: AW]   = AW'($urandom % 16);
                wdata[p*DW +: DW]  = DW'($urandom);
                wmask[p*DW +: DW]  = ($urandom % 2) ? '1 : DW'($urandom);
            end
        end
        mgnt = ($urandom % 5) != 0;
    endtask

    logic [N-1:0] lg  [8];
    logic [N-1:0] lr0 [8];
    logic [N-1:0] lr1 [8];
    logic [N-1:0] eg  [8];
    logic [N-1:0] er0 [8];
    logic [N-1:0] er1 [8];

    initial begin
        for (int i = 0; i < 4096; i++) mem[i] = DW'($urandom);
        for (int d = 0; d < 2; d++) begin
            em[d]  = 1'b0;
            mrv[d] = 1'b0;
            mrd[d] = '0;
            for (int s = 0; s < 4; s++) begin
                sp_v[d][s] = 1'b0;
                sp_d[d][s] = '0;
            end
        end
        eg  = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00};
        er0 = '{2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00, 2'b00, 2'b00};
        er1 = '{2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 2'b01, 2'b10, 2'b00};

        rst = 1'b1;
        cycle();
        do_reset();

        // Idle after reset: everything quiet.
        cycle();
        chk_value("t1_gnt", 64'(obs_gnt), 64'(0));
        chk_value("t1_rvalid", 64'(obs_rv[0]), 64'(0));
        chk_value("t1_err", 64'(obs_err[1]), 64'(0));

        // Both ports reading continuously: alternating grants and responses.
        mgnt = 1'b1;
        we   = '0;
        addr = {12'h005, 12'h004};
        for (int c = 0; c < 8; c++) begin
            req = (c < 4) ? 2'b11 : 2'b00;
            cycle();
            lg[c]  = obs_gnt;
            lr0[c] = obs_rv[0];
            lr1[c] = obs_rv[1];
        end
        for (int c = 0; c < 8; c++) begin
            chk_value("t2_gnt_seq", 64'(lg[c]), 64'(eg[c]));
            chk_value("t2_rv_lat1", 64'(lr0[c]), 64'(er0[c]));
            chk_value("t5_rv_lat3", 64'(lr1[c]), 64'(er1[c]));
        end

        // Read, write, read-back of the written word.
        req = 2'b01; we = 2'b00; addr[0 +: AW] = 12'h010;
        cycle();
        req = 2'b10; we = 2'b10; addr[AW +: AW] = 12'h020;
        wdata[DW +: DW] = 32'hDEADBEEF; wmask[DW +: DW] = '1;
        cycle();
        chk_value("t3_rv_p0", 64'(obs_rv[0]), 64'(2'b01));
        we = 2'b00;
        cycle();
        chk_value("t3_no_wr_rv", 64'(obs_rv[0]), 64'(0));
        req = 2'b00;
        cycle();
        chk_value("t3_rv_p1", 64'(obs_rv[0]), 64'(2'b10));
        chk_value("t3_rdata", 64'(obs_rd[0]), 64'(32'hDEADBEEF));

        // SRAM stall: no grant, and the same winner once the stall lifts.
        req = 2'b11; we = 2'b00; mgnt = 1'b0;
        for (int c = 0; c < 3; c++) begin
            cycle();
            chk_value("t4_stall_gnt", 64'(obs_gnt), 64'(0));
        end
        mgnt = 1'b1;
        cycle();
        chk_value("t4_resume_gnt", 64'(obs_gnt), 64'(2'b01));
        req = 2'b00;
        repeat (4) cycle();

        // Spurious response with nothing in flight.
        mrv[0] = 1'b1; mrv[1] = 1'b1;
        mrd[0] = 32'h1234; mrd[1] = 32'h1234;
        cycle();
        chk_value("t6_spur_rv0", 64'(obs_rv[0]), 64'(0));
        chk_value("t6_spur_rv1", 64'(obs_rv[1]), 64'(0));
        cycle();
        chk_value("t6_err0", 64'(obs_err[0]), 64'(1));
        chk_value("t6_err1", 64'(obs_err[1]), 64'(1));

        // Reset while a read is in flight.
        do_reset();
        req = 2'b01; we = 2'b00; addr[0 +: AW] = 12'h033;
        cycle();
        do_reset();
        for (int c = 0; c < 4; c++) begin
            cycle();
            chk_value("t6_rst_rv1", 64'(obs_rv[1]), 64'(0));
        end
        chk_value("t6_rst_err1", 64'(obs_err[1]), 64'(1));
        chk_value("t6_rst_err0", 64'(obs_err[0]), 64'(0));

        // Randomized traffic with occasional resets.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            cycle();
            if (i % 1000 == 999) do_reset();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
